sync_fifo_param: RTL
====================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter WIDTH, default 12: data word width in bits.
REQ-002 Parameter DEPTH, default 640: word capacity; any integer >= 2, power of two not required.
REQ-003 Parameter HF_LEVEL, default DEPTH/2: half-full threshold in words.
REQ-004 Parameter AF_LEVEL, default DEPTH-2: almost-full threshold in words.
REQ-005 Parameter AE_LEVEL, default 2: almost-empty threshold in words.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 wr_en  in  1  write request.
REQ-009 data_in  in  WIDTH  write data.
REQ-010 rd_en  in  1  read request.
REQ-011 data_out  out  WIDTH  read data.
REQ-012 full, empty, half_full, almost_full, almost_empty  out  1 each  status flags.
REQ-013 count  out  CW = clog2(DEPTH+1)  stored-word count.
REQ-014 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-015 Write accepted when wr_en=1 and (full=0, or rd_en=1 with read accepted); word stored at wr_ptr, wr_ptr advances.
REQ-016 Read accepted when rd_en=1 and empty=0; rd_ptr advances.
REQ-017 Pointers are clog2(DEPTH) bits and wrap DEPTH-1 -> 0 by explicit compare, never by natural overflow.
REQ-018 count: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read+write or on no accepted operation.
REQ-019 Full with wr_en=1 and rd_en=1: both accepted, count stays DEPTH.
REQ-020 Empty with wr_en=1 and rd_en=1: write only accepted, count becomes 1, underflow set.
REQ-021 Flags combinational from registered count: full = (count==DEPTH); empty = (count==0); half_full = (count>=HF_LEVEL); almost_full = (count>=AF_LEVEL); almost_empty = (count<=AE_LEVEL).
REQ-022 wr_en=1 while full and read not accepted: write dropped, memory and wr_ptr unchanged, overflow set.
REQ-023 rd_en=1 while empty: read dropped, data_out unchanged, underflow set.
REQ-024 overflow/underflow remain 1 until reset.
REQ-025 Standard mode: data_out registered, takes word at rd_ptr on the edge that accepts the read (1-cycle latency), holds otherwise.

Reset
REQ-026 rst=1 at a clock edge: rd_ptr=0, wr_ptr=0, count=0, data_out=0, overflow=0, underflow=0; empty=1, almost_empty=1, other flags 0.
REQ-027 rst overrides wr_en/rd_en in the same cycle; memory contents not cleared; reset mid-burst discards all stored words.

Configuration
REQ-028 Macro SYNC_FIFO_FWFT_EN defined: first-word-fall-through; data_out = memory[rd_ptr] continuously while empty=0, 0 when empty; rd_en pops current word, next word visible the following cycle.
REQ-029 Macro undefined: standard mode per REQ-025; port list identical in both modes.

Structure
REQ-030 Package fifo_pkg holds the clog2 width function and default threshold constants.
REQ-031 Storage in sub-module fifo_ram: DEPTH x WIDTH, one synchronous write port, one read port (registered in standard mode, asynchronous in FWFT).

Verification (DEPTH=8, WIDTH=12, HF=4, AF=6, AE=2)
REQ-032 Reset, write 0x001..0x008 -> count 1..8; almost_empty clears at count 3, half_full at 4, almost_full at 6, full at 8.
REQ-033 Full, wr_en with data 0xABC, rd_en=0 -> overflow=1, count 8; subsequent 8 reads return 0x001..0x008, 0xABC never appears.
REQ-034 Empty, rd_en=1 -> underflow=1, data_out holds last value, count 0; wr+rd together on empty -> count 1.
REQ-035 Full, wr_en+rd_en with 0x100 -> count 8, read returns 0x001; drain: 0x002..0x008 then 0x100 (wrap verified).
REQ-036 Write 0x055, 0x0AA, then assert rst=1 for one cycle with wr_en=1 -> count 0, empty=1, overflow=0, underflow=0, no word stored.
REQ-037 FWFT build: single write 0x3C3 -> data_out=0x3C3 one cycle after write with no rd_en; standard build -> data_out=0x3C3 one cycle after rd_en accepted.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and width helper for the synchronous FIFO slice.
// Used by sync_fifo_param and fifo_ram in both the standard and SYNC_FIFO_FWFT_EN builds.
package fifo_pkg;

    localparam int unsigned DEF_WIDTH    = 12;
    localparam int unsigned DEF_DEPTH    = 640;
    localparam int unsigned DEF_AE_LEVEL = 2;

    // Bits needed to encode values 0..n-1, never less than one.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage with one synchronous write port and one read port.
// The read port is registered by default and asynchronous when SYNC_FIFO_FWFT_EN is defined.
module fifo_ram #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 640,
    parameter int unsigned AW    = 10
) (
    input  logic             clk,
`ifndef SYNC_FIFO_FWFT_EN
    input  logic             rst,
    input  logic             re,
`endif
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata = mem[raddr];
`else
    // Read register updates only on an accepted read, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO with status thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned HF_LEVEL = DEPTH / 2,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              data_in,
    input  logic                          rd_en,
    output logic [WIDTH-1:0]              data_out,
    output logic                          full,
    output logic                          empty,
    output logic                          half_full,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [clog2(DEPTH+1)-1:0]     count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = clog2(DEPTH + 1);

    logic [AW-1:0]    wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [CW-1:0]    count_n;
    logic             overflow_n, underflow_n;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] ram_q;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign half_full    = (count >= CW'(HF_LEVEL));
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    // A write into a full FIFO is accepted only when a read frees a slot in the same cycle.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_n    = wr_ptr;
        rd_ptr_n    = rd_ptr;
        count_n     = count;
        overflow_n  = overflow;
        underflow_n = underflow;
        if (wr_acc) begin
            wr_ptr_n = (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_n = (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
        if (wr_en && !wr_acc) begin
            overflow_n = 1'b1;
        end
        if (rd_en && empty) begin
            underflow_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            count     <= count_n;
            overflow  <= overflow_n;
            underflow <= underflow_n;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
`ifndef SYNC_FIFO_FWFT_EN
        .rst   (rst),
        .re    (rd_acc),
`endif
        .we    (wr_acc && !rst),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out = empty ? '0 : ram_q;
`else
    assign data_out = ram_q;
`endif

endmodule
